// File: rtl/matmul_pkg.sv
// Types and constants shared by the matrix loader, systolic controller and result transmitter.
package matmul_pkg;

  typedef logic [15:0] mat4x4_t [0:3][0:3];

  localparam int unsigned CLKS_PER_BIT_125M_115200 = 1085;
  localparam logic [7:0]  SYNC_BYTE                = 8'hA5;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} seq_state_e;

  typedef enum logic [1:0] {SerIdle, SerStartBit, SerData, SerStopBit} ser_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a byte offered during the last stop-bit cycle follows with no gap.
module uart_tx_byte
  import matmul_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_125M_115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       frame_end_o,
  output logic       tx_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  ser_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            tc;

  assign tc = (cnt_q == CntMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SerIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != SerIdle) cnt_d = tc ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      SerIdle: begin
        if (valid_i) begin
          shift_d = data_i;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = SerStartBit;
        end
      end
      SerStartBit: begin
        if (tc) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = SerData;
        end
      end
      SerData: begin
        if (tc) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = SerStopBit;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      SerStopBit: begin
        if (tc) begin
          if (valid_i) begin
            shift_d = data_i;
            tx_d    = 1'b0;
            state_d = SerStartBit;
          end else begin
            state_d = SerIdle;
          end
        end
      end
    endcase
  end

  always_comb begin
    ready_o     = (state_q == SerIdle) || ((state_q == SerStopBit) && tc);
    frame_end_o = (state_q == SerStopBit) && tc && !valid_i;
    tx_o        = tx_q;
  end

endmodule

// File: rtl/result_uart_tx.sv
// Streams a snapshot of the 4x4 result matrix over UART: optional sync byte, then each
// element high byte first in row-major order.
module result_uart_tx
  import matmul_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_125M_115200,
  parameter bit          HEADER_EN    = 1'b1,
  parameter logic [7:0]  HEADER       = SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] C [0:3][0:3],
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned NumBytes = HEADER_EN ? 33 : 32;
  localparam logic [5:0]  LastIdx  = 6'(NumBytes - 1);

  seq_state_e  state_q, state_d;
  logic [5:0]  byte_idx_q, byte_idx_d;
  logic        armed_q, armed_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  mat4x4_t     snap_q, snap_d;

  logic        ser_valid, ser_ready, ser_frame_end, ser_tx;
  logic [4:0]  pay_idx;
  logic [15:0] elem;
  logic [7:0]  ser_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_idx_q <= '0;
      armed_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) snap_q[r][c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      snap_q     <= snap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    armed_d    = armed_q;
    snap_d     = snap_q;
    unique case (state_q)
      StIdle: begin
        if (!start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d    = 1'b0;
          snap_d     = C;
          byte_idx_d = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (ser_ready) begin
          if (byte_idx_q == LastIdx) state_d = StWait;
          else byte_idx_d = byte_idx_q + 6'd1;
        end
      end
      StWait: if (ser_frame_end) state_d = StDone;
      StDone: state_d = StIdle;
    endcase
    // busy rises with the start bit, one cycle after the request is accepted
    busy_d = (state_q != StIdle) && (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_comb begin
    pay_idx   = HEADER_EN ? 5'(byte_idx_q - 6'd1) : byte_idx_q[4:0];
    elem      = snap_q[pay_idx[4:3]][pay_idx[2:1]];
    ser_data  = (HEADER_EN && (byte_idx_q == 6'd0)) ? HEADER
              : (pay_idx[0] ? elem[7:0] : elem[15:8]);
    ser_valid = (state_q == StLoad);
    tx        = ser_tx;
    busy      = busy_q;
    done      = done_q;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .valid_i    (ser_valid),
    .data_i     (ser_data),
    .ready_o    (ser_ready),
    .frame_end_o(ser_frame_end),
    .tx_o       (ser_tx)
  );

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench: three instances (header on/off at 4 clocks per bit, full-rate timing).
module tb_result_uart_tx;

  typedef struct {
    logic [15:0] c_in;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, rst_n1, rst_n2;
  logic        start0, start1, start2;
  logic [15:0] c0 [0:3][0:3];
  logic [15:0] c1 [0:3][0:3];
  logic [15:0] c2 [0:3][0:3];
  logic        tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;

  int errors = 0;
  int checks = 0;
  int dcnt0 = 0;
  int dcnt1 = 0;
  int sel = 0;
  logic rx_tx, rx_busy, rx_done;
  int   rx_dcnt;
  vec_t tbl [16];
  logic [7:0] exp_q [$];

  result_uart_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1'b1), .HEADER(8'hA5)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .start(start0), .C(c0), .tx(tx0), .busy(busy0), .done(done0)
  );
  result_uart_tx #(.CLKS_PER_BIT(4), .HEADER_EN(1'b0), .HEADER(8'hA5)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .C(c1), .tx(tx1), .busy(busy1), .done(done1)
  );
  result_uart_tx #(.CLKS_PER_BIT(1085), .HEADER_EN(1'b1), .HEADER(8'hA5)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .C(c2), .tx(tx2), .busy(busy2), .done(done2)
  );

  always @(posedge clk) begin
    if (done0) dcnt0 <= dcnt0 + 1;
    if (done1) dcnt1 <= dcnt1 + 1;
  end

  always_comb begin
    if (sel == 0) begin
      rx_tx = tx0; rx_busy = busy0; rx_done = done0; rx_dcnt = dcnt0;
    end else begin
      rx_tx = tx1; rx_busy = busy1; rx_done = done1; rx_dcnt = dcnt1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_exp(input bit hdr, input bit all_ff);
    exp_q = {};
    if (hdr) exp_q.push_back(8'hA5);
    for (int e = 0; e < 16; e++) begin
      exp_q.push_back(all_ff ? 8'hFF : tbl[e].exp_hi);
      exp_q.push_back(all_ff ? 8'hFF : tbl[e].exp_lo);
    end
  endtask

  // Called right after the launch edge; samples every bit mid-period at its exact slot.
  task automatic rx_frame(input int nb, input int cpb);
    logic [7:0] b;
    int d_start;
    d_start = rx_dcnt;
    @(posedge clk);
    repeat (cpb / 2) @(posedge clk);
    for (int n = 0; n < nb; n++) begin
      b = '0;
      for (int i = 0; i < 10; i++) begin
        if (!(n == 0 && i == 0)) repeat (cpb) @(posedge clk);
        @(negedge clk);
        if (i == 0) begin
          chk($sformatf("start_bit[%0d]", n), 32'(rx_tx), 32'd0);
          if (n == 0) chk("busy_first_bit", 32'(rx_busy), 32'd1);
        end else if (i == 9) begin
          chk($sformatf("stop_bit[%0d]", n), 32'(rx_tx), 32'd1);
        end else begin
          b[i-1] = rx_tx;
        end
      end
      chk($sformatf("byte[%0d]", n), 32'(b), 32'(exp_q[n]));
    end
    repeat (cpb - cpb / 2) @(posedge clk);
    @(negedge clk);
    chk("done_at_end", 32'({rx_done, rx_busy, rx_tx}), 32'b101);
    @(negedge clk);
    chk("done_one_cycle", 32'(rx_done), 32'd0);
    chk("done_count", 32'(rx_dcnt - d_start), 32'd1);
  endtask

  task automatic idle_check(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rx_tx !== 1'b1 || rx_busy !== 1'b0 || rx_done !== 1'b0) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_before, n_low;

    tbl[0]  = '{16'h0000, 8'h00, 8'h00};
    tbl[1]  = '{16'h0001, 8'h00, 8'h01};
    tbl[2]  = '{16'h0002, 8'h00, 8'h02};
    tbl[3]  = '{16'h0003, 8'h00, 8'h03};
    tbl[4]  = '{16'h0100, 8'h01, 8'h00};
    tbl[5]  = '{16'h0101, 8'h01, 8'h01};
    tbl[6]  = '{16'h0102, 8'h01, 8'h02};
    tbl[7]  = '{16'h0103, 8'h01, 8'h03};
    tbl[8]  = '{16'h0200, 8'h02, 8'h00};
    tbl[9]  = '{16'h0201, 8'h02, 8'h01};
    tbl[10] = '{16'h0202, 8'h02, 8'h02};
    tbl[11] = '{16'h0203, 8'h02, 8'h03};
    tbl[12] = '{16'h0300, 8'h03, 8'h00};
    tbl[13] = '{16'h0301, 8'h03, 8'h01};
    tbl[14] = '{16'h0302, 8'h03, 8'h02};
    tbl[15] = '{16'h0303, 8'h03, 8'h03};

    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    for (int e = 0; e < 16; e++) begin
      c0[e/4][e%4] = tbl[e].c_in;
      c1[e/4][e%4] = 16'hFFFF;
      c2[e/4][e%4] = tbl[e].c_in;
    end
    repeat (3) @(negedge clk);
    chk("reset_dut0", 32'({tx0, busy0, done0}), 32'b100);
    chk("reset_dut1", 32'({tx1, busy1, done1}), 32'b100);
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;

    // Idle with start low
    sel = 0;
    idle_check("idle_100", 100);

    // Header frame, start held high throughout and afterwards
    build_exp(1'b1, 1'b0);
    start0 = 1'b1;
    @(posedge clk);
    rx_frame(33, 4);
    idle_check("no_retrigger", 200);
    start0 = 1'b0;

    // Headerless all-FF frame; C zeroed after capture
    sel = 1;
    build_exp(1'b0, 1'b1);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    fork
      rx_frame(32, 4);
      begin
        @(posedge clk);
        @(negedge clk);
        for (int e = 0; e < 16; e++) c1[e/4][e%4] = 16'h0000;
        start1 = 1'b0;
      end
    join

    // Reset during byte 5, data bit 3
    sel = 0;
    build_exp(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    d_before = dcnt0;
    start0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    repeat (54 * 4 + 2) @(posedge clk);
    @(negedge clk);
    chk("tx_before_reset", 32'(tx0), 32'd0);
    start0 = 1'b0;
    #1 rst_n0 = 1'b0;
    #1 chk("tx_async_reset", 32'({tx0, busy0}), 32'b10);
    repeat (4) @(negedge clk);
    chk("no_done_on_reset", 32'(dcnt0 - d_before), 32'd0);
    rst_n0 = 1'b1;
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    fork
      rx_frame(33, 4);
      begin @(negedge clk); start0 = 1'b0; end
    join

    // Second start pulse mid-frame is ignored; a fresh request sends another frame
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    fork
      rx_frame(33, 4);
      begin
        @(negedge clk);
        start0 = 1'b0;
        repeat (400) @(negedge clk);
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b0;
      end
    join
    idle_check("single_frame", 60);
    start0 = 1'b1;
    @(posedge clk);
    rx_frame(33, 4);
    start0 = 1'b0;

    // Full-rate start-bit period
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("tx2_idle_before_k1", 32'(tx2), 32'd1);
    n_low = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx2 !== 1'b0) break;
      n_low++;
    end
    chk("start_bit_1085", 32'(n_low), 32'd1085);
    rst_n2 = 1'b0;
    start2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Serializes the 4x4 result matrix from the systolic array into a fixed UART byte stream for the host. It is the transmit counterpart of the matrix loader: the loader assembles received bytes into `mem_a`/`mem_b`, and this block flattens `C[0:3][0:3]` back into bytes. It sits between the systolic controller output and the `tx` pin, and the main controller drives it with a level `start` and receives a `done` pulse back.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1085: clock cycles per UART bit (125 MHz / 115200 baud).
- `HEADER_EN`, default 1: when 1, send sync byte `HEADER` before the payload.
- `HEADER`, default 8'hA5: sync byte value.

Ports:
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: level request from the main controller.
- `C`, input, [15:0] x [0:3][0:3]: result matrix, unsigned.
- `tx`, output, 1: UART line, idle high.
- `busy`, output, 1: high from frame launch until `done`.
- `done`, output, 1: one-cycle pulse after the last stop bit.

## Operation
- Frame format: 8N1. One start bit (0), 8 data bits sent LSB first, one stop bit (1). There is no gap between bytes.
- Byte sequence:
  - `HEADER` first, if `HEADER_EN`.
  - Then the 16 elements in row-major order, `C[0][0]`, `C[0][1]` … `C[3][3]`.
  - Each element is sent high byte first, then low byte.
  - Total is 33 bytes (32 with `HEADER_EN`=0).
- `C` is captured into an internal snapshot register on the cycle `start` is accepted. Changes to `C` after capture are ignored.
- State machine:
  - IDLE: waits for `start` high while the `armed` flag is set.
  - LOAD: selects the next byte from the snapshot.
  - START_BIT → DATA (8 bits) → STOP_BIT.
  - After STOP_BIT, go to LOAD if bytes remain, otherwise DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Re-arm rule:
  - `armed` clears when `start` is accepted.
  - `armed` sets only when `start` is sampled low in IDLE.
  - A `start` still held high through DONE/IDLE does not retrigger.
- Counters:
  - Bit-time counter runs 0..`CLKS_PER_BIT`-1; the bit advances on terminal count.
  - Bit index runs 0..7.
  - Byte index is 6 bits and runs 0..32. It does not wrap; reaching the last index goes to DONE.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, `armed`=1, all counters 0, snapshot 0.
- `rst_n` low mid-frame forces `tx` high immediately (asynchronous). The partial frame is abandoned and `done` is not pulsed.
- `start` sampled high at edge k (in IDLE, armed):
  - `busy` and `tx`=0 (start bit) from edge k+1.
  - Each bit holds exactly `CLKS_PER_BIT` cycles.
- The last stop bit ends at edge k+1+10·NB·`CLKS_PER_BIT`, where NB = 33 or 32.
  - At that edge `done` goes high for exactly one cycle and `busy` falls.
  - `tx` stays 1.
- `start` arriving while `busy` is ignored.
- `start` falling mid-frame does not abort the transfer.
- `tx` is driven from a register, so it has no combinational glitches.

## Structure
- Shared package `matmul_pkg`:
  - `typedef logic [15:0] mat4x4_t [0:3][0:3];`
  - `localparam CLKS_PER_BIT_125M_115200 = 1085;`
  - `SYNC_BYTE = 8'hA5`.
  - This package is also used by the loader and the systolic controller.
- One sub-module, `uart_tx_byte`:
  - 8N1 serializer with a `valid`/`ready` byte handshake, owning the bit-time counter and bit index.
  - The parent owns the byte sequencer, snapshot, `armed` and `done`.

## Test plan
Test plan uses `CLKS_PER_BIT`=4 unless stated.
- Reset, then hold `start`=0 for 100 cycles → `tx`=1, `busy`=0, `done`=0 throughout.
- `C[i][j]` = 16'h0100·i + j, `start` held high → decoded bytes are A5, 00 00, 00 01, 00 02, 00 03, 01 00 … 03 03. `done` pulses once at start+1+1320 cycles. No retrigger while `start` stays high for 200 more cycles.
- `C` all 16'hFFFF, `HEADER_EN`=0; change `C` to 0 one cycle after `start` → 32 bytes of FF; total 1280 cycles; every stop bit is 1.
- Deassert `rst_n` during byte 5, bit 3 → `tx` goes 1 asynchronously, with no `done`. A new `start` after release produces a complete, correct 33-byte frame.
- `start` pulsed high twice: once at launch and again mid-frame → exactly one frame and one `done`. After `start` returns low and high again, a second full frame is sent.
- `CLKS_PER_BIT`=1085 → a bit-period measurement on the first start bit gives exactly 1085 cycles.
